// File: rtl/gnn_0_example_pkg.sv
// Shared definitions for the gnn_0_example ping-pong feature buffer.
// Defaults track the load stage's AXI data width and per-bank depth.
package gnn_0_example_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 512;
   localparam int unsigned ADDR_WIDTH_DEF = 9;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

   function automatic logic bank_writable(input bank_state_e s);
      return (s == BANK_EMPTY) || (s == BANK_FILLING);
   endfunction

endpackage

// File: rtl/gnn_0_example_sdp_ram.sv
// Simple dual-port RAM with a one-cycle registered read.
// The array is never reset; only the read register is, so rd_data is 0 out of reset.
module gnn_0_example_sdp_ram
   import gnn_0_example_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/gnn_0_example_pingpong_buffer.sv
// Double-buffered feature store between the load stage (writer) and compute (reader).
// Bank ownership passes via load_done (close write bank) and rd_release (free read bank).
//
// Per-bank state:
//   state        | meaning
//   BANK_EMPTY   | free, open for writing, no words yet
//   BANK_FILLING | open for writing, at least one word written
//   BANK_FULL    | closed by load_done, readable until rd_release
module gnn_0_example_pingpong_buffer
   import gnn_0_example_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  kernel_clk,
   input  logic                  kernel_rst,
   input  logic                  load_write_buffer_valid,
   input  logic [ADDR_WIDTH-1:0] load_write_buffer_addr,
   input  logic [DATA_WIDTH-1:0] load_write_buffer_data,
   input  logic                  load_done,
   output logic                  wr_bank_ready,
   output logic                  rd_bank_valid,
   output logic [ADDR_WIDTH:0]   rd_bank_words,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_data_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_release,
   output logic                  wr_overflow,
   output logic                  rd_underflow
);

   bank_state_e         state_q [2];
   bank_state_e         state_d [2];
   logic [ADDR_WIDTH:0] words_q [2];
   logic [ADDR_WIDTH:0] words_d [2];
   logic                wr_sel_q, wr_sel_d;
   logic                rd_sel_q, rd_sel_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic                rd_valid_q, rd_valid_d;
   logic                rst_done_q;

   logic                wr_accept;
   logic                rd_accept;
   logic [ADDR_WIDTH:0] wr_words;

   // Holding ready low until the first edge after reset keeps every output 0 in reset.
   assign wr_bank_ready = rst_done_q && bank_writable(state_q[wr_sel_q]);
   assign rd_bank_valid = (state_q[rd_sel_q] == BANK_FULL);
   assign rd_bank_words = words_q[rd_sel_q];
   assign rd_data_valid = rd_valid_q;
   assign wr_overflow   = overflow_q;
   assign rd_underflow  = underflow_q;

   assign wr_accept = load_write_buffer_valid && wr_bank_ready;
   assign rd_accept = rd_en && rd_bank_valid;
   assign wr_words  = {1'b0, load_write_buffer_addr} + (ADDR_WIDTH + 1)'(1);

   always_ff @(posedge kernel_clk or posedge kernel_rst) begin
      if (kernel_rst) begin
         state_q[0]  <= BANK_EMPTY;
         state_q[1]  <= BANK_EMPTY;
         words_q[0]  <= '0;
         words_q[1]  <= '0;
         wr_sel_q    <= 1'b0;
         rd_sel_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rst_done_q  <= 1'b0;
      end else begin
         state_q[0]  <= state_d[0];
         state_q[1]  <= state_d[1];
         words_q[0]  <= words_d[0];
         words_q[1]  <= words_d[1];
         wr_sel_q    <= wr_sel_d;
         rd_sel_q    <= rd_sel_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rd_valid_q  <= rd_valid_d;
         rst_done_q  <= 1'b1;
      end
   end

   // Write side only touches bank wr_sel, read side only bank rd_sel. A writable
   // bank is never FULL, so the two sides can never land on the same bank.
   always_comb begin
      state_d     = state_q;
      words_d     = words_q;
      wr_sel_d    = wr_sel_q;
      rd_sel_d    = rd_sel_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      rd_valid_d  = rd_accept;

      if (wr_accept) begin
         if (state_q[wr_sel_q] == BANK_EMPTY) begin
            state_d[wr_sel_q] = BANK_FILLING;
         end
         if (wr_words > words_q[wr_sel_q]) begin
            words_d[wr_sel_q] = wr_words;
         end
      end

      if (load_done && wr_bank_ready) begin
         state_d[wr_sel_q] = BANK_FULL;
         wr_sel_d          = ~wr_sel_q;
      end

      if ((load_write_buffer_valid || load_done) && !wr_bank_ready) begin
         overflow_d = 1'b1;
      end

      if (rd_release && rd_bank_valid) begin
         state_d[rd_sel_q] = BANK_EMPTY;
         words_d[rd_sel_q] = '0;
         rd_sel_d          = ~rd_sel_q;
      end

      if (rd_en && !rd_bank_valid) begin
         underflow_d = 1'b1;
      end
   end

   gnn_0_example_sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH + 1)
   ) u_ram (
      .clk     (kernel_clk),
      .rst     (kernel_rst),
      .wr_en   (wr_accept),
      .wr_addr ({wr_sel_q, load_write_buffer_addr}),
      .wr_data (load_write_buffer_data),
      .rd_en   (rd_accept),
      .rd_addr ({rd_sel_q, rd_addr}),
      .rd_data (rd_data)
   );

endmodule

// File: doc/gnn_0_example_pingpong_buffer.md
Name: gnn_0_example_pingpong_buffer

Overview:
- Double-buffered on-chip feature buffer directly downstream of gnn_0_example_load.
- Absorbs the load stage's buffer write port (valid/addr/data) into one of two banks.
- Simultaneously serves registered reads of the other, already-filled bank to the compute stage.
- Bank ownership is handed over via load_done (producer) and rd_release (consumer), so DRAM loading overlaps with compute.

Parameters:
- DATA_WIDTH, 512, word width; equals load AXI data width.
- ADDR_WIDTH, 9, per-bank address width; depth 2^ADDR_WIDTH = 512 words per bank.

Ports:
- kernel_clk  in  1  clock.
- kernel_rst  in  1  reset, asynchronous, active-high.
- load_write_buffer_valid  in  1  write strobe from load stage.
- load_write_buffer_addr  in  ADDR_WIDTH  word address within the current write bank.
- load_write_buffer_data  in  DATA_WIDTH  write data.
- load_done  in  1  one-cycle pulse (load ap_done); closes the current write bank.
- wr_bank_ready  out  1  a bank is open for writing.
- rd_bank_valid  out  1  a filled bank is available to the consumer.
- rd_bank_words  out  ADDR_WIDTH+1  word count of the readable bank (highest written addr + 1).
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read word address in the current read bank.
- rd_data_valid  out  1  read data valid; 1 cycle after an accepted rd_en.
- rd_data  out  DATA_WIDTH  read data.
- rd_release  in  1  one-cycle pulse; consumer finished with the read bank.
- wr_overflow  out  1  sticky: write seen while no bank was open.
- rd_underflow  out  1  sticky: rd_en seen while rd_bank_valid=0.

Behaviour:
- Per-bank state, 2 bits: EMPTY, FILLING, FULL.
  - Writes always target bank wr_sel; reads always target bank rd_sel.
- Reset, async: both banks EMPTY; wr_sel=0, rd_sel=0; bank word counts 0.
  - All outputs 0, except wr_bank_ready=1 one cycle after reset deassert.
  - Memory contents are not cleared.
- wr_bank_ready = state[wr_sel] is EMPTY or FILLING.
- Write accepted when valid && wr_bank_ready:
  - Store data at {wr_sel, addr}.
  - EMPTY becomes FILLING.
  - words[wr_sel] = max(words[wr_sel], addr+1).
- Write while !wr_bank_ready: dropped; wr_overflow set (cleared only by reset).
- load_done while wr_bank_ready:
  - state[wr_sel] becomes FULL; wr_sel toggles.
  - A write in the same cycle is committed to the closing bank first, and its addr counts toward words.
- load_done on an EMPTY bank (zero-word load): bank becomes FULL with words=0.
- load_done while !wr_bank_ready: ignored; wr_overflow set.
- rd_bank_valid = state[rd_sel] is FULL; rd_bank_words = words[rd_sel].
- Read accepted when rd_en && rd_bank_valid:
  - rd_data registered from {rd_sel, rd_addr} at the next edge.
  - rd_data_valid=1 for exactly that cycle.
  - Back-to-back reads give one result per cycle.
- rd_en while !rd_bank_valid: no data; rd_data_valid=0; rd_underflow set.
- rd_release while rd_bank_valid:
  - state[rd_sel] becomes EMPTY; words cleared; rd_sel toggles.
  - A read in the same cycle still returns data from the released bank.
  - rd_release while !rd_bank_valid is ignored.
- load_done and rd_release in the same cycle: both apply independently. They address different banks by construction.
- Both banks FULL: wr_bank_ready=0 until rd_release. The next write bank then becomes ready on the following cycle.
- No read/write collision: a bank is never writable and readable at once.
- Reset mid-operation: everything returns to the reset state; an in-flight read result is discarded (rd_data_valid=0).

Decomposition:
- Shared package: DATA_WIDTH/ADDR_WIDTH defaults (512/9, matching load) and bank-state encodings EMPTY=2'd0, FILLING=2'd1, FULL=2'd2.
- One sub-module, gnn_0_example_sdp_ram: simple dual-port RAM, depth 2*2^ADDR_WIDTH, 1-cycle registered read, no reset on the array.
- Top level holds the bank state machines, pointers, word counters and error flags.

Test Plan:
- Reset then write addr 0..1 (data 2,1), load_done → rd_bank_valid=1, rd_bank_words=2; reads of addr 0,1 return 2,1 on consecutive cycles, rd_data_valid high 2 cycles.
- Fill bank0 with 16 words, load_done; fill bank1 with 128 words while reading bank0 → bank0 data intact; after rd_release, rd_bank_words=128 and bank1 data correct.
- Both banks FULL, extra write to addr 5 → wr_overflow=1, wr_bank_ready=0, no data corrupted; rd_release → wr_bank_ready=1 next cycle.
- rd_en with no FULL bank → rd_data_valid stays 0, rd_underflow=1.
- Same-cycle write(addr 7) + load_done, and separately same-cycle load_done + rd_release → closing bank words=8; both state transitions take effect; pointers toggle.
- Assert kernel_rst mid-fill and mid-read → all states EMPTY, flags 0, rd_data_valid=0, wr_bank_ready=1 after release.
